// File: rtl/wr_event_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wr_event_capture_pkg
// Description : Shared definitions for the write-event capture block:
//               capture FSM state encoding, sequence-number width and the
//               event record width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wr_event_capture_pkg;

    // Capture FSM state encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_WAIT = 2'd1,
        CAP_HELD = 2'd2
    } cap_state_t;

    localparam int SEQ_W = 16;

    // Event record is {addr, data, seq}.
    function automatic int evt_width(input int aw, input int dw);
        return aw + dw + SEQ_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wr_event_capture_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : evt_fifo
// Description : Synchronous circular-buffer FIFO. Pointers carry one extra
//               wrap bit to distinguish full from empty. A push into a full
//               FIFO is accepted only if a pop happens in the same cycle;
//               otherwise it is dropped and the sticky overflow flag is set.
//               No empty-FIFO bypass: pushed data appears the next cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push, i_data  - write request and record
//               i_ready         - consumer accepts head this cycle
//               o_valid, o_data - head present / head record
//               o_level         - occupancy (0..DEPTH)
//               o_overflow      - sticky, an event was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 78
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] c_ptr_one = PW'(1);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IW] != r_rd_ptr[IW]) &&
                     (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    // When full, the slot being written is the one being popped, so a
    // simultaneous pop frees it in time for the write at the same edge.
    assign w_write = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr[IW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = r_mem[r_rd_ptr[IW-1:0]];
    assign o_level    = r_wr_ptr - r_rd_ptr;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/wr_event_capture.sv
`default_nettype none
// ============================================================================
// Module      : wr_event_capture
// Description : Samples the CPU data-memory write port and turns each store
//               into exactly one event, even when mem_wen is held across
//               cache stalls. Events {addr, data, seq} are buffered in a
//               FIFO and presented on a valid/ready interface.
// Ports       : clk, rst                     - clock, sync active-high reset
//               mem_addr/mem_data/mem_wen    - CPU write port
//               mem_stall                    - data cache stall
//               out_valid/out_ready          - event handshake
//               out_addr/out_data/out_seq    - head event fields
//               overflow                     - sticky drop indicator
//               level                        - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wr_event_capture
    import wr_event_capture_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    input  logic                   mem_wen,
    input  logic                   mem_stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_addr,
    output logic [DW-1:0]          out_data,
    output logic [SEQ_W-1:0]       out_seq,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int EW = evt_width(AW, DW);

    cap_state_t       r_state;
    cap_state_t       w_next_state;
    logic             w_capture;
    logic             w_differs;
    logic [AW-1:0]    r_last_addr;
    logic [DW-1:0]    r_last_data;
    logic [SEQ_W-1:0] r_seq;
    logic [EW-1:0]    w_head;

    // In HELD, a still-asserted enable is only a new store when the
    // address or data changed since the last capture.
    assign w_differs = (mem_addr != r_last_addr) || (mem_data != r_last_data);

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (mem_wen && mem_stall) begin
                    w_next_state = CAP_WAIT;
                end else if (mem_wen) begin
                    w_capture    = 1'b1;
                    w_next_state = CAP_HELD;
                end
            end
            CAP_WAIT: begin
                if (!mem_wen) begin
                    w_next_state = CAP_IDLE;
                end else if (!mem_stall) begin
                    w_capture    = 1'b1;
                    w_next_state = CAP_HELD;
                end
            end
            CAP_HELD: begin
                if (!mem_wen) begin
                    w_next_state = CAP_IDLE;
                end else if (!mem_stall && w_differs) begin
                    w_capture = 1'b1;
                end
            end
            default: begin
                w_next_state = CAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CAP_IDLE;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_seq       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_last_addr <= mem_addr;
                r_last_data <= mem_data;
                // Increments even when the FIFO drops the event, leaving a
                // visible gap in the sequence.
                r_seq       <= r_seq + 16'd1;
            end
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_evt_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_capture),
        .i_data     ({mem_addr, mem_data, r_seq}),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_data     (w_head),
        .o_level    (level),
        .o_overflow (overflow)
    );

    assign {out_addr, out_data, out_seq} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_wr_event_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_event_capture
// Description : Directed self-checking bench for wr_event_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_event_capture;

    logic        clk;
    logic        rst;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wen;
    logic        mem_stall;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_addr;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic        overflow;
    logic [2:0]  level;

    int n_pass;
    int n_total;

    wr_event_capture #(
        .DEPTH (4),
        .AW    (30),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wen   (mem_wen),
        .mem_stall (mem_stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_wen   = 1'b0;
        mem_stall = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({out_valid, level, overflow} !== 5'b0)
            $display("FAIL reset_flags: valid=%0b level=%0d ovf=%0b, want 0 0 0", out_valid, level, overflow);
        else n_pass++;
        n_total++;
        if ({out_addr, out_data, out_seq} !== 78'd0)
            $display("FAIL reset_head: addr=%0h data=%0h seq=%0d, want 0 0 0", out_addr, out_data, out_seq);
        else n_pass++;
    endtask

    task automatic test_single_store();
        do_reset();
        mem_wen = 1'b1; mem_addr = 30'd0; mem_data = 32'd150;
        tick();
        mem_wen = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || level !== 3'd1)
            $display("FAIL single_valid: valid=%0b level=%0d, want 1 1", out_valid, level);
        else n_pass++;
        n_total++;
        if (out_addr !== 30'd0 || out_data !== 32'd150 || out_seq !== 16'd0)
            $display("FAIL single_event: addr=%0d data=%0d seq=%0d, want 0 150 0", out_addr, out_data, out_seq);
        else n_pass++;
        tick();
        n_total++;
        if (level !== 3'd1)
            $display("FAIL single_no_dup: level=%0d, want 1", level);
        else n_pass++;
    endtask

    task automatic test_stalled_store();
        do_reset();
        mem_wen = 1'b1; mem_addr = 30'd5; mem_data = 32'hAB; mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (level !== 3'd0)
                $display("FAIL stall_cycle%0d: level=%0d, want 0", c + 1, level);
            else n_pass++;
        end
        mem_stall = 1'b0;
        tick();
        n_total++;
        if (level !== 3'd1 || out_seq !== 16'd0 || out_data !== 32'hAB)
            $display("FAIL stall_capture: level=%0d seq=%0d data=%0h, want 1 0 ab", level, out_seq, out_data);
        else n_pass++;
        tick();
        mem_wen = 1'b0;
        tick();
        n_total++;
        if (level !== 3'd1)
            $display("FAIL stall_single_event: level=%0d, want 1", level);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_wen = 1'b1; mem_addr = 30'd8;
        mem_data = 32'd1; tick();
        mem_data = 32'd2; tick();
        mem_data = 32'd2; tick();
        mem_wen = 1'b0; tick();
        n_total++;
        if (level !== 3'd2)
            $display("FAIL b2b_level: level=%0d, want 2", level);
        else n_pass++;
        n_total++;
        if (out_data !== 32'd1 || out_seq !== 16'd0)
            $display("FAIL b2b_first: data=%0d seq=%0d, want 1 0", out_data, out_seq);
        else n_pass++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_total++;
        if (out_data !== 32'd2 || out_seq !== 16'd1 || level !== 3'd1)
            $display("FAIL b2b_second: data=%0d seq=%0d level=%0d, want 2 1 1", out_data, out_seq, level);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_seq  [4];
        logic [29:0] exp_addr [4];
        exp_seq  = '{16'd1, 16'd2, 16'd3, 16'd5};
        exp_addr = '{30'd17, 30'd18, 30'd19, 30'h40};
        do_reset();
        mem_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_addr = 30'(16 + i); mem_data = 32'(100 + i);
            tick();
        end
        mem_wen = 1'b0;
        n_total++;
        if (level !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_full: level=%0d ovf=%0b, want 4 1", level, overflow);
        else n_pass++;
        n_total++;
        if (out_seq !== 16'd0 || out_addr !== 30'd16)
            $display("FAIL ovf_head: seq=%0d addr=%0d, want 0 16", out_seq, out_addr);
        else n_pass++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        mem_wen = 1'b1; mem_addr = 30'h40; mem_data = 32'h500;
        tick();
        mem_wen = 1'b0;
        n_total++;
        if (level !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_refill: level=%0d ovf=%0b, want 4 1", level, overflow);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_seq !== exp_seq[i] || out_addr !== exp_addr[i])
                $display("FAIL ovf_drain%0d: valid=%0b seq=%0d addr=%0h, want 1 %0d %0h",
                         i, out_valid, out_seq, out_addr, exp_seq[i], exp_addr[i]);
            else n_pass++;
            out_ready = 1'b1; tick();
        end
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1)
            $display("FAIL ovf_empty: valid=%0b level=%0d ovf=%0b, want 0 0 1", out_valid, level, overflow);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        mem_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 30'(32 + i); mem_data = 32'(i);
            tick();
        end
        mem_wen = 1'b0; tick();
        n_total++;
        if (level !== 3'd4 || overflow !== 1'b0)
            $display("FAIL fpp_full: level=%0d ovf=%0b, want 4 0", level, overflow);
        else n_pass++;
        mem_wen = 1'b1; mem_addr = 30'h77; mem_data = 32'h77; out_ready = 1'b1;
        tick();
        mem_wen = 1'b0; out_ready = 1'b0;
        n_total++;
        if (level !== 3'd4 || overflow !== 1'b0 || out_seq !== 16'd1)
            $display("FAIL fpp_swap: level=%0d ovf=%0b seq=%0d, want 4 0 1", level, overflow, out_seq);
        else n_pass++;
        out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
        n_total++;
        if (out_addr !== 30'h77 || out_seq !== 16'd4 || level !== 3'd1)
            $display("FAIL fpp_tail: addr=%0h seq=%0d level=%0d, want 77 4 1", out_addr, out_seq, level);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mem_wen = 1'b1; mem_stall = 1'b1; mem_addr = 30'd9; mem_data = 32'h99;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_stall = 1'b0;
        n_total++;
        if (level !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL rst_flush: level=%0d valid=%0b, want 0 0", level, out_valid);
        else n_pass++;
        tick();
        mem_wen = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_data !== 32'h99 || level !== 3'd1)
            $display("FAIL rst_new_store: valid=%0b seq=%0d data=%0h level=%0d, want 1 0 99 1",
                     out_valid, out_seq, out_data, level);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_store();
        test_stalled_store();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
